// File: rtl/dec_sel_pipe.sv
// Decode-select stage: picks one of NSRC decoder bundles by source index and
// registers it into a two-entry skid buffer with valid/ready on both sides.
module dec_sel_pipe #(
  parameter  int NSRC = 2,
  parameter  int OPW  = 96,
  parameter  int PCW  = 64,
  parameter  int CNTW = 32,
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SELW-1:0]     in_sel,
  input  logic [NSRC*OPW-1:0] in_ops,
  input  logic [PCW-1:0]      in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPW-1:0]      out_ops,
  output logic [PCW-1:0]      out_pc,
  output logic                out_ill,
  output logic                out_comp,
  output logic [CNTW-1:0]     issued_cnt
);

  // state | meaning
  // EMPTY | nothing buffered
  // ONE   | main register holds the output entry
  // FULL  | main holds the output entry, skid holds the next one
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  localparam int EW = OPW + PCW + 2;

  state_t          state_q, state_d;
  logic [EW-1:0]   main_q, main_d;
  logic [EW-1:0]   skid_q, skid_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [OPW-1:0]  sel_ops;
  logic            sel_legal;
  logic [EW-1:0]   entry;
  logic            in_fire, out_fire;

  always_comb begin
    sel_ops   = '0;
    sel_legal = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SELW'(k)) begin
        sel_ops   = in_ops[k*OPW +: OPW];
        sel_legal = 1'b1;
      end
    end
  end

  assign entry = {sel_ops, in_pc, ~sel_legal, (in_sel == '0)};

  // in_ready is a function of registered state only, so no path from out_ready
  assign in_ready  = (state_q != FULL) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = out_fire ? cnt_q + CNTW'(1) : cnt_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = entry;
        end else if (in_fire) begin
          skid_d  = entry;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // flush drops buffered and incoming entries; a same-cycle out_fire still counts
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_ops    = main_q[EW-1 -: OPW];
  assign out_pc     = main_q[PCW+1:2];
  assign out_ill    = main_q[1];
  assign out_comp   = main_q[0];
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_dec_sel_pipe.sv
// Bench for dec_sel_pipe (NSRC=3, CNTW=4): queue-based occupancy model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_dec_sel_pipe;

  localparam int NSRC = 3;
  localparam int OPW  = 32;
  localparam int PCW  = 16;
  localparam int CNTW = 4;
  localparam int SELW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [SELW-1:0]     in_sel;
  logic [NSRC*OPW-1:0] in_ops;
  logic [PCW-1:0]      in_pc;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [OPW-1:0]      out_ops;
  logic [PCW-1:0]      out_pc;
  logic                out_ill;
  logic                out_comp;
  logic [CNTW-1:0]     issued_cnt;

  dec_sel_pipe #(.NSRC(NSRC), .OPW(OPW), .PCW(PCW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_ops(in_ops), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ops(out_ops),
    .out_pc(out_pc), .out_ill(out_ill), .out_comp(out_comp),
    .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [OPW-1:0] ops;
    logic [PCW-1:0] pc;
    bit             ill;
    bit             comp;
  } ent_t;

  ent_t q[$];
  int   mcnt = 0;

  always @(posedge clk) begin
    bit   rdy, ofire;
    ent_t e;
    rdy   = (q.size() < 2) && !rst;
    ofire = (q.size() > 0) && out_ready;
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (ofire) begin
        void'(q.pop_front());
        mcnt = (mcnt + 1) % 16;
      end
      if (flush) q.delete();
      else if (in_valid && rdy) begin
        e.ill  = (in_sel >= 3);
        e.comp = (in_sel == 0);
        e.ops  = e.ill ? '0 : OPW'(in_ops >> (32 * int'(in_sel)));
        e.pc   = in_pc;
        q.push_back(e);
      end
    end
  end

  logic [PCW-1:0] olog[$];
  int             low_cnt = 0;

  always @(negedge clk) begin
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, (q.size() < 2) && !rst);
    chk("issued_cnt", issued_cnt, mcnt);
    if (q.size() > 0) begin
      chk("out_ops", out_ops, q[0].ops);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_ill", out_ill, q[0].ill);
      chk("out_comp", out_comp, q[0].comp);
    end
    if (out_valid && out_ready && !rst) olog.push_back(out_pc);
    if (!in_ready && !rst) low_cnt++;
  end

  task automatic cyc(input bit v, input logic [1:0] s, input logic [15:0] p,
                     input bit ordy, input bit fl);
    in_valid  = v;
    in_sel    = s;
    in_pc     = p;
    in_ops    = {8'hA2, 8'h00, p, 8'hA1, 8'h00, p, 8'hA0, 8'h00, p};
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3, input int n);
    logic [15:0] exp[4];
    exp = '{e0, e1, e2, e3};
    chk({nm, "_len"}, olog.size(), n);
    for (int i = 0; i < n && i < olog.size(); i++) chk(nm, olog[i], exp[i]);
  endtask

  task automatic chk_reset_vals();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cnt", issued_cnt, 0);
    chk("rst_ops", out_ops, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_ill", out_ill, 0);
    chk("rst_comp", out_comp, 0);
  endtask

  initial begin
    int cnt_before;
    rst = 1'b1;
    cyc(0, 0, 16'h0, 0, 0);
    cyc(0, 0, 16'h0, 0, 0);
    cyc(0, 0, 16'h0, 0, 0);
    chk_reset_vals();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // basic select and illegal source
    cyc(1, 0, 16'h1000, 1, 0);
    chk("sel0_ops", out_ops, 32'hA000_1000);
    chk("sel0_pc", out_pc, 16'h1000);
    chk("sel0_comp", out_comp, 1);
    cyc(1, 1, 16'h1004, 1, 0);
    chk("sel1_ops", out_ops, 32'hA100_1004);
    chk("sel1_comp", out_comp, 0);
    cyc(1, 3, 16'h1008, 1, 0);
    chk("ill_flag", out_ill, 1);
    chk("ill_ops", out_ops, 0);
    cyc(1, 2, 16'h100C, 1, 0);
    chk("sel2_ops", out_ops, 32'hA200_100C);
    cyc(0, 0, 16'h0, 1, 0);
    chk("basic_valid", out_valid, 0);
    chk("basic_cnt", issued_cnt, 4);

    // stream with a single-cycle stall
    rst = 1'b1;
    cyc(0, 0, 16'h0, 1, 0);
    rst = 1'b0;
    olog.delete();
    low_cnt = 0;
    cyc(1, 0, 16'h0, 1, 0);
    cyc(1, 0, 16'h4, 1, 0);
    cyc(1, 0, 16'h8, 0, 0);
    cyc(1, 0, 16'hC, 1, 0);
    cyc(1, 0, 16'hC, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);
    chk_log("stream_pc", 16'h0, 16'h4, 16'h8, 16'hC, 4);
    chk("stream_low", low_cnt, 1);
    chk("stream_cnt", issued_cnt, 4);

    // full hold for five cycles then release
    olog.delete();
    cyc(1, 0, 16'h20, 0, 0);
    cyc(1, 0, 16'h24, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 16'h28, 0, 0);
      chk("hold_pc", out_pc, 16'h20);
      chk("hold_ready", in_ready, 0);
    end
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);
    chk_log("hold_pc_seq", 16'h20, 16'h24, 16'h0, 16'h0, 2);
    chk("hold_cnt", issued_cnt, 6);

    // flush while FULL with incoming entry
    olog.delete();
    cyc(1, 0, 16'h30, 0, 0);
    cyc(1, 0, 16'h34, 0, 0);
    cnt_before = 6;
    cyc(1, 0, 16'h38, 0, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_cnt", issued_cnt, cnt_before);
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);
    chk("flush_log_len", olog.size(), 0);

    // flush in ONE with a simultaneous output handshake
    cyc(1, 0, 16'h40, 1, 0);
    cyc(1, 0, 16'h44, 1, 1);
    chk("flush1_valid", out_valid, 0);
    chk("flush1_cnt", issued_cnt, 7);
    cyc(0, 0, 16'h0, 1, 0);
    chk_log("flush1_pc", 16'h40, 16'h0, 16'h0, 16'h0, 1);

    // counter wrap: 17 handshakes on a 4-bit counter
    rst = 1'b1;
    cyc(0, 0, 16'h0, 1, 0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) cyc(1, 1, 16'(16'h100 + 4 * i), 1, 0);
    cyc(0, 0, 16'h0, 1, 0);
    chk("wrap_cnt", issued_cnt, 1);

    // reset mid-stream with the buffer full
    cyc(1, 0, 16'h50, 0, 0);
    cyc(1, 1, 16'h54, 0, 0);
    rst = 1'b1;
    cyc(1, 0, 16'h58, 1, 0);
    chk_reset_vals();
    rst = 1'b0;
    #1;
    chk("ready_after_rst2", in_ready, 1);
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_sel_pipe.md
# dec_sel_pipe

Parametrised decode-select stage that picks one of NSRC decoder output bundles (16-bit compressed, 32-bit, and further decoders such as a microcode expander) by a per-instruction source index. It registers the selected bundle into a 2-entry skid buffer with valid/ready handshakes on both sides. It sits between the parallel decoders and the ID/EX boundary, replacing the purely combinational 16/32 select. It adds back-pressure, pipeline flush, illegal-source detection and an issued-instruction counter.

## Interface
- NSRC, 2: number of decoder sources, 2..8
- OPW, 96: width of one packed op bundle (alu/io/bj/sys ops concatenated)
- PCW, 64: instruction address width
- CNTW, 32: issued-instruction counter width
- SELW, derived = max(1, $clog2(NSRC)): source index width

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream bundle set valid
- in_ready  out  1  stage can accept this cycle
- in_sel  in  SELW  source index; 0 = compressed, 1 = 32-bit, others per decoder
- in_ops  in  NSRC*OPW  decoder bundles; source k occupies bits [k*OPW +: OPW]
- in_pc  in  PCW  instruction PC
- flush  in  1  discard all buffered and incoming entries
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_ops  out  OPW  selected bundle
- out_pc  out  PCW  PC of output entry
- out_ill  out  1  in_sel was >= NSRC; out_ops is all-zero
- out_comp  out  1  entry came from source 0
- issued_cnt  out  CNTW  count of out handshakes since reset

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Select: sel_ops = in_ops[in_sel*OPW +: OPW] when in_sel < NSRC. Otherwise sel_ops = 0 and ill = 1. comp = (in_sel == 0).
- Entry = {sel_ops, in_pc, ill, comp}. Selection is combinational before the registers. Nothing downstream sees an unregistered path.
- Storage: main register (drives out_*) and skid register. State is EMPTY, ONE or FULL. out_valid = (state != EMPTY). in_ready = (state != FULL) & ~rst.
- EMPTY: in_fire -> main <= entry, ONE.
- ONE:
  - in_fire & out_fire -> main <= entry, stay ONE.
  - in_fire & ~out_ready -> skid <= entry, FULL.
  - ~in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL: in_ready = 0. out_fire -> main <= skid, ONE. Otherwise hold.
- Order is preserved: skid entry always leaves after the main entry.
- flush (priority below rst, above everything else): next state EMPTY. Any in_fire in the same cycle is discarded. An out_fire in the same cycle still completes and is counted.
- issued_cnt increments by 1 on each out_fire and wraps modulo 2^CNTW. It is not cleared by flush.
- out_* payload holds its value while out_valid & ~out_ready. Payload is don't-care when out_valid = 0.

## Timing
- Reset: state EMPTY, out_valid 0, in_ready 0 while rst = 1 and 1 in the first cycle after, issued_cnt 0, out_ops/out_pc/out_ill/out_comp 0.
- Latency: in_fire at cycle N -> out_valid with that entry at N+1 (from EMPTY, or from ONE with simultaneous out_fire).
- Throughput: 1 entry/cycle sustained with out_ready held 1.
- in_ready depends only on registered state, with no combinational path from out_ready. This removes the ready chain into the decoders.
- Back-pressure: out_ready low for one cycle with a continuous input stream -> FULL at next edge. in_ready drops for exactly the cycles the stage remains FULL.
- flush at N -> out_valid = 0 and in_ready = 1 at N+1.
- rst asserted mid-stream -> all entries lost, issued_cnt 0 at the next edge.

## Test plan
- Basic select, NSRC=2: in_sel=0 with bundle A=0x…AAAA in slot 0 and B in slot 1, pc=0x1000 -> next cycle out_ops=A, out_comp=1, out_pc=0x1000. Then in_sel=1 -> out_ops=B, out_comp=0.
- Illegal source, NSRC=3, SELW=2: in_sel=3 -> out_ill=1, out_ops=0. Entry still handshakes and issued_cnt increments.
- Stream with stall: send pcs 0x0,0x4,0x8,0xC every cycle, out_ready=0 during cycle 2 only -> in_ready=0 for one cycle. Outputs arrive in order 0x0,0x4,0x8,0xC with none lost or duplicated. issued_cnt=4.
- Full hold: fill to FULL with out_ready=0 for 5 cycles -> out_pc stable, in_ready=0 throughout. Releasing gives two outputs on consecutive cycles.
- Flush in FULL with simultaneous in_valid: next cycle out_valid=0, in_ready=1. Flushed and incoming entries never appear. issued_cnt unchanged.
- Counter wrap, CNTW=4: 17 out_fires -> issued_cnt=1. Pulse rst mid-stream -> all outputs at reset values the following cycle.
